// File: rtl/led_pwm_driver_pkg.sv
// Shared types and defaults for the LED PWM output stage.
// State encodings and board-level LED constants.
package led_pwm_driver_pkg;

    localparam int LED_WIDTH        = 5;
    localparam int LED_PWM_BITS     = 4;
    localparam int LED_HOLD_PERIODS = 4;

    typedef enum logic [1:0] {
        LED_EMPTY = 2'd0,
        LED_SHOW  = 2'd1,
        LED_HOLD  = 2'd2
    } led_state_e;

endpackage

// File: rtl/pwm_timebase.sv
// Free-running PWM counter, wrap strobe and brightness latch.
// Brightness is only taken at period wrap so a period is never cut short.
module pwm_timebase #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] brightness_i,
    output logic                wrap_o,
    output logic                pwm_on_o
);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] bright_q;

    assign wrap_o = &pwm_cnt_q;

    // Full-scale brightness means 100% duty, not 15/16.
    assign pwm_on_o = (&bright_q) ? 1'b1 : (pwm_cnt_q < bright_q);

    // Counter runs every cycle; brightness latched at the wrap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            bright_q  <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            if (wrap_o) begin
                bright_q <= brightness_i;
            end
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// LED output stage: one-deep pattern buffer, dwell FSM and PWM-gated drive.
// Pattern changes only happen at PWM period boundaries.
module led_pwm_driver
    import led_pwm_driver_pkg::*;
#(
    parameter int WIDTH        = LED_WIDTH,
    parameter int PWM_BITS     = LED_PWM_BITS,
    parameter int HOLD_PERIODS = LED_HOLD_PERIODS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pattern_valid,
    input  logic [WIDTH-1:0]    pattern_data,
    output logic                pattern_ready,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [WIDTH-1:0]    leds,
    output logic                busy
);

    localparam int DW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
    localparam logic [DW-1:0] DWELL_INIT = DW'(HOLD_PERIODS - 1);

    led_state_e       state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             pending_full_q, pending_full_d;
    logic [WIDTH-1:0] current_q, current_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [WIDTH-1:0] leds_q;

    logic wrap;
    logic pwm_on;
    logic accept;
    logic load;

    pwm_timebase #(
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .brightness_i (brightness),
        .wrap_o       (wrap),
        .pwm_on_o     (pwm_on)
    );

    assign pattern_ready = !pending_full_q;
    assign accept        = pattern_valid && pattern_ready;
    assign busy          = (state_q == LED_SHOW) || pending_full_q;
    assign leds          = leds_q;

    // Decide at each wrap whether the pending pattern is promoted.
    always_comb begin
        load = 1'b0;
        if (wrap && pending_full_q) begin
            unique case (state_q)
                LED_EMPTY,
                LED_HOLD: load = 1'b1;
                LED_SHOW: load = (dwell_q == '0);
                default:  load = 1'b0;
            endcase
        end
    end

    // Next-state for FSM, pending slot and dwell counter.
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        current_d      = current_q;
        dwell_d        = dwell_q;

        if (accept) begin
            pending_d      = pattern_data;
            pending_full_d = 1'b1;
        end

        if (load) begin
            current_d      = pending_q;
            pending_full_d = 1'b0;
            dwell_d        = DWELL_INIT;
            state_d        = LED_SHOW;
        end else if (wrap && state_q == LED_SHOW) begin
            if (dwell_q != '0) begin
                dwell_d = dwell_q - 1'b1;
            end else begin
                state_d = LED_HOLD;
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= LED_EMPTY;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            current_q      <= '0;
            dwell_q        <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            current_q      <= current_d;
            dwell_q        <= dwell_d;
        end
    end

    // Registered LED drive, gated by the PWM duty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds_q <= '0;
        end else if (state_q == LED_EMPTY) begin
            leds_q <= '0;
        end else begin
            leds_q <= current_q & {WIDTH{pwm_on}};
        end
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed and random bench for led_pwm_driver.
// A cycle-count reference model predicts leds/busy/ready every cycle.
module tb_led_pwm_driver;

    localparam int W      = 5;
    localparam int PB     = 4;
    localparam int HP     = 4;
    localparam int PER    = 1 << PB;
    localparam int SHOWCY = HP * PER;

    logic          clk;
    logic          rst_n;
    logic          pattern_valid;
    logic [W-1:0]  pattern_data;
    logic          pattern_ready;
    logic [PB-1:0] brightness;
    logic [W-1:0]  leds;
    logic          busy;

    int total;
    int bad;

    // reference model: dwell tracked as remaining clock cycles
    logic [W-1:0]  m_pend;
    logic [W-1:0]  m_cur;
    logic [W-1:0]  m_leds;
    logic [PB-1:0] m_bright;
    bit            m_full;
    bit            m_shown;
    bit            m_acc;
    int            m_left;
    int            m_phase;

    led_pwm_driver #(
        .WIDTH        (W),
        .PWM_BITS     (PB),
        .HOLD_PERIODS (HP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pattern_valid (pattern_valid),
        .pattern_data  (pattern_data),
        .pattern_ready (pattern_ready),
        .brightness    (brightness),
        .leds          (leds),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pend   = '0;
        m_cur    = '0;
        m_leds   = '0;
        m_bright = '0;
        m_full   = 0;
        m_shown  = 0;
        m_acc    = 0;
        m_left   = 0;
        m_phase  = 0;
    endtask

    task automatic m_step();
        bit on;
        bit wrap;
        on     = (m_bright == PB'(PER - 1)) ? 1'b1 : (m_phase < int'(m_bright));
        m_leds = (m_shown && on) ? m_cur : '0;
        m_acc  = pattern_valid && !m_full;
        wrap   = (m_phase == PER - 1);
        if (m_left > 0) m_left--;
        if (wrap && m_left == 0 && m_full) begin
            m_cur   = m_pend;
            m_full  = 0;
            m_shown = 1;
            m_left  = SHOWCY;
        end
        if (m_acc) begin
            m_pend = pattern_data;
            m_full = 1;
        end
        if (wrap) m_bright = brightness;
        m_phase = (m_phase + 1) % PER;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) m_reset();
        else m_step();
        @(negedge clk);
        chk("leds", 32'(leds), 32'(m_leds));
        chk("busy", 32'(busy), 32'(m_left > 0 || m_full));
        chk("ready", 32'(pattern_ready), 32'(!m_full));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [W-1:0] p);
        bit done;
        done          = 0;
        pattern_data  = p;
        pattern_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            done = m_acc;
        end
        chk("accept_timeout", 32'(done), 32'd1);
        pattern_valid = 1'b0;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        pattern_valid = 1'b0;
        pattern_data  = '0;
        brightness    = '0;
        m_reset();

        // reset state
        run(3);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(pattern_ready), 32'd1);
        rst_n = 1'b1;

        // full brightness single pattern, then HOLD
        brightness = 4'd15;
        send(5'b10101);
        run(100);
        chk("hold_leds", 32'(leds), 32'h15);
        chk("hold_busy", 32'(busy), 32'd0);

        // 25% duty, then dark
        brightness = 4'd4;
        send(5'b11111);
        run(90);
        brightness = 4'd0;
        run(40);
        chk("dark_leds", 32'(leds), 32'd0);

        // back-to-back with backpressure
        brightness = 4'd15;
        send(5'b11111);
        send(5'b00001);
        send(5'b01010);
        run(200);
        chk("b2b_last", 32'(leds), 32'h0a);

        // brightness drop in the middle of a period
        while (m_phase != 7) tick();
        brightness = 4'd0;
        run(40);

        // random patterns, random gaps and brightness
        for (int k = 0; k < 20; k++) begin
            brightness = PB'($urandom_range(0, PER - 1));
            send(W'($urandom));
            run($urandom_range(0, 30));
        end
        brightness = 4'd15;
        run(300);

        // async reset in the middle of a dwell
        send(5'b10011);
        for (int i = 0; i < 400 && m_left < 20; i++) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_leds", 32'(leds), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        m_reset();
        @(negedge clk);
        run(2);
        rst_n = 1'b1;
        run(20);
        send(5'b00110);
        run(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
